// File: rtl/store_buffer_coalesce_pkg.sv
// Shared definitions for the store buffer: size encodings, drain FSM states and
// byte-lane helpers used by both the buffer and its forwarding lookup.
package store_buffer_coalesce_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } drain_state_e;

  function automatic logic [3:0] byte_mask(input logic [1:0] lo, input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lo;
      SZ_HALF: m = 4'b0011 << lo;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic is_aligned(input logic [1:0] lo, input logic [1:0] size);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (lo[0] == 1'b0);
      SZ_WORD: ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] lane_shift(input logic [31:0] d, input logic [1:0] lo);
    return d << {lo, 3'b000};
  endfunction

  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    logic [31:0] e;
    for (int b = 0; b < 4; b++) e[8*b +: 8] = {8{m[b]}};
    return e;
  endfunction

  // Keeps only the bytes a right-aligned load of this size returns.
  function automatic logic [31:0] size_keep(input logic [1:0] size);
    logic [31:0] k;
    case (size)
      SZ_BYTE: k = 32'h0000_00FF;
      SZ_HALF: k = 32'h0000_FFFF;
      SZ_WORD: k = 32'hFFFF_FFFF;
      default: k = 32'h0000_0000;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/store_buffer_coalesce_fwd_lookup.sv
// Combinational youngest-first store-to-load forwarding match over the buffer
// entries; the first intersecting entry decides between hit and conflict.
module sb_fwd_lookup
  import store_buffer_coalesce_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT,
  parameter int ADDR_W   = 32,
  localparam int PTR_W   = $clog2(SB_DEPTH)
) (
  input  logic                               ld_req,
  input  logic [ADDR_W-1:0]                  ld_addr,
  input  logic [1:0]                         ld_size,
  input  logic [SB_DEPTH-1:0]                valid,
  input  logic [SB_DEPTH-1:0][ADDR_W-3:0]    waddr,
  input  logic [SB_DEPTH-1:0][3:0]           mask,
  input  logic [SB_DEPTH-1:0][31:0]          data,
  input  logic [PTR_W-1:0]                   head,
  output logic                               ld_hit,
  output logic                               ld_conflict,
  output logic [31:0]                        ld_data
);

  logic [3:0]       lmask;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    ld_hit      = 1'b0;
    ld_conflict = 1'b0;
    ld_data     = 32'h0;
    found       = 1'b0;
    idx         = '0;
    lmask       = byte_mask(ld_addr[1:0], ld_size);
    // Age order: i=0 is the youngest entry (head-1), wrapping back to the oldest.
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head - PTR_W'(i + 1);
      if (!found && valid[idx] && (waddr[idx] == ld_addr[ADDR_W-1:2]) &&
          ((mask[idx] & lmask) != 4'b0000)) begin
        found = 1'b1;
        if ((mask[idx] & lmask) == lmask) begin
          ld_hit  = 1'b1;
          ld_data = (data[idx] >> {ld_addr[1:0], 3'b000}) & size_keep(ld_size);
        end else begin
          ld_conflict = 1'b1;
        end
      end
    end
    if (!ld_req) begin
      ld_hit      = 1'b0;
      ld_conflict = 1'b0;
      ld_data     = 32'h0;
    end
  end

endmodule

// File: rtl/store_buffer_coalesce.sv
// Circular store buffer between LSU and dcache with byte masks, forwarding and a
// valid/ready drain port. Define SB_COALESCE_EN to merge stores into the youngest entry.
module store_buffer_coalesce
  import store_buffer_coalesce_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT,
  parameter int ADDR_W   = 32,
  localparam int CNT_W   = $clog2(SB_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  input  logic              dtlb_hit,
  output logic              st_misalign,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  output logic              ld_hit,
  output logic              ld_conflict,
  output logic [31:0]       ld_data,
  input  logic              drain_force,
  output logic              dc_valid,
  input  logic              dc_ready,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [31:0]       dc_data,
  output logic [3:0]        dc_be,
  output logic              full_out,
  output logic              empty_out
);

  // Drain handshake: a beat transfers on a rising clk edge where dc_valid && dc_ready;
  // dc_addr/dc_data/dc_be stay stable while dc_valid is high and dc_ready is low.

  localparam int PTR_W = $clog2(SB_DEPTH);

  logic [SB_DEPTH-1:0]             valid_q;
  logic [SB_DEPTH-1:0][ADDR_W-3:0] waddr_q;
  logic [SB_DEPTH-1:0][3:0]        mask_q;
  logic [SB_DEPTH-1:0][31:0]       data_q;
  logic [PTR_W-1:0]                head_q, tail_q, youngest;
  logic [CNT_W-1:0]                count_q;
  drain_state_e                    state_q, state_d;

  logic             st_aligned, merge_ok, merge_block, accept, do_alloc, do_merge;
  logic [3:0]       st_mask;
  logic [31:0]      st_lane;
  logic             drain_cond, load_dc, clear_dc, pop;
  logic [PTR_W-1:0] load_idx;

  assign full_out   = (count_q == CNT_W'(SB_DEPTH));
  assign empty_out  = (count_q == '0);
  assign youngest   = head_q - PTR_W'(1);
  assign st_aligned = is_aligned(st_addr[1:0], st_size);
  assign st_mask    = byte_mask(st_addr[1:0], st_size);
  assign st_lane    = lane_shift(st_data, st_addr[1:0]) & expand_mask(st_mask);
  assign drain_cond = !empty_out && (full_out || !st_valid || drain_force);

  always_comb begin
    state_d  = state_q;
    load_dc  = 1'b0;
    clear_dc = 1'b0;
    pop      = 1'b0;
    load_idx = tail_q;
    case (state_q)
      S_IDLE: begin
        if (drain_cond) begin
          load_dc = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (dc_ready) begin
          pop = 1'b1;
          if (drain_cond && (count_q > CNT_W'(1))) begin
            load_dc  = 1'b1;
            load_idx = tail_q + PTR_W'(1);
          end else begin
            clear_dc = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // An entry being sent, or being captured into dc_* this cycle, must not absorb a merge.
  assign merge_block = ((state_q == S_SEND) && (youngest == tail_q)) ||
                       (load_dc && (youngest == load_idx));

`ifdef SB_COALESCE_EN
  assign merge_ok = !empty_out && valid_q[youngest] &&
                    (waddr_q[youngest] == st_addr[ADDR_W-1:2]) && !merge_block;
`else
  assign merge_ok = 1'b0;
`endif

  assign st_ready = !full_out || merge_ok;
  assign accept   = st_valid && dtlb_hit && st_aligned && st_ready;
  assign do_merge = accept && merge_ok;
  assign do_alloc = accept && !merge_ok;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      waddr_q     <= '0;
      mask_q      <= '0;
      data_q      <= '0;
      dc_valid    <= 1'b0;
      dc_addr     <= '0;
      dc_data     <= '0;
      dc_be       <= '0;
      st_misalign <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_misalign <= st_valid && dtlb_hit && !st_aligned;
      if (do_alloc) begin
        valid_q[head_q] <= 1'b1;
        waddr_q[head_q] <= st_addr[ADDR_W-1:2];
        mask_q[head_q]  <= st_mask;
        data_q[head_q]  <= st_lane;
        head_q          <= head_q + PTR_W'(1);
      end
      if (do_merge) begin
        mask_q[youngest] <= mask_q[youngest] | st_mask;
        data_q[youngest] <= (data_q[youngest] & ~expand_mask(st_mask)) | st_lane;
      end
      if (pop) begin
        valid_q[tail_q] <= 1'b0;
        tail_q          <= tail_q + PTR_W'(1);
      end
      case ({do_alloc, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (load_dc) begin
        dc_valid <= 1'b1;
        dc_addr  <= {waddr_q[load_idx], 2'b00};
        dc_data  <= data_q[load_idx];
        dc_be    <= mask_q[load_idx];
      end else if (clear_dc) begin
        dc_valid <= 1'b0;
      end
    end
  end

  sb_fwd_lookup #(
    .SB_DEPTH (SB_DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_fwd (
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_size     (ld_size),
    .valid       (valid_q),
    .waddr       (waddr_q),
    .mask        (mask_q),
    .data        (data_q),
    .head        (head_q),
    .ld_hit      (ld_hit),
    .ld_conflict (ld_conflict),
    .ld_data     (ld_data)
  );

endmodule

// File: tb/tb_store_buffer_coalesce.sv
// Directed and randomized checks of store_buffer_coalesce against a queue-based
// reference model; honours SB_COALESCE_EN when the design is built with it.
module tb_store_buffer_coalesce;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        st_valid, st_ready, dtlb_hit, st_misalign;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        ld_req, ld_hit, ld_conflict;
  logic [31:0] ld_addr, ld_data;
  logic [1:0]  ld_size;
  logic        drain_force, dc_valid, dc_ready;
  logic [31:0] dc_addr, dc_data;
  logic [3:0]  dc_be;
  logic        full_out, empty_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [29:0] w;
    logic [3:0]  m;
    logic [31:0] d;
  } entry_t;
  entry_t mq[$];

  logic        prev_stall;
  logic [31:0] prev_addr;

  always #5 clk = ~clk;

  store_buffer_coalesce dut (
    .clk(clk), .reset_n(reset_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .dtlb_hit(dtlb_hit),
    .st_misalign(st_misalign), .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_hit(ld_hit), .ld_conflict(ld_conflict), .ld_data(ld_data),
    .drain_force(drain_force), .dc_valid(dc_valid), .dc_ready(dc_ready),
    .dc_addr(dc_addr), .dc_data(dc_data), .dc_be(dc_be),
    .full_out(full_out), .empty_out(empty_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz; dtlb_hit = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; st_valid = 1'b0; dtlb_hit = 1'b1; ld_req = 1'b0;
    dc_ready = 1'b0; drain_force = 1'b0;
    st_addr = '0; st_data = '0; st_size = 2'b10; ld_addr = '0; ld_size = 2'b10;
    tick(); tick();
    reset_n = 1'b1;
    mq = {};
    prev_stall = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    st_valid = 1'b0; dc_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (empty_out && !dc_valid) break;
      tick();
    end
    chk(tag, {31'b0, empty_out}, 32'd1);
    dc_ready = 1'b0;
  endtask

  function automatic logic [3:0] m_mask(input logic [1:0] lo, input logic [1:0] sz);
    case (sz)
      2'b00: return 4'b0001 << lo;
      2'b01: return 4'b0011 << lo;
      2'b10: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] m_bytes(input logic [3:0] m);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = 8'hFF;
    return r;
  endfunction

  // Reference forwarding: youngest-first search over the model queue.
  task automatic model_fwd(input logic [31:0] a, input logic [1:0] sz,
                           output logic h, output logic c, output logic [31:0] d);
    logic [3:0] lm;
    int lo;
    lm = m_mask(a[1:0], sz); lo = int'(a[1:0]);
    h = 1'b0; c = 1'b0; d = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].w == a[31:2] && (mq[i].m & lm) != 4'b0) begin
        if ((mq[i].m & lm) == lm) begin
          h = 1'b1;
          for (int b = 0; b < 4; b++) if (lm[b]) d[8*(b-lo) +: 8] = mq[i].d[8*b +: 8];
        end else begin
          c = 1'b1;
        end
        break;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr(input logic [1:0] sz);
    logic [1:0] lo;
    case (sz)
      2'b00: lo = 2'($urandom_range(0, 3));
      2'b01: lo = {1'($urandom_range(0, 1)), 1'b0};
      default: lo = 2'b00;
    endcase
    return 32'h500 + 32'($urandom_range(0, 3)) * 4 + 32'(lo);
  endfunction

  // One cycle of model-checked operation with the inputs already driven.
  task automatic run_cycle();
    logic eh, ec, ymatch, merge, exp_ready, accept, hs;
    logic [31:0] ed;
    logic [3:0]  sm;
    entry_t      e;
    int          lo;
    #1;
    ymatch = (mq.size() > 0) && (mq[mq.size()-1].w == st_addr[31:2]);
`ifdef SB_COALESCE_EN
    merge = ymatch && !(dc_valid && mq.size() == 1);
`else
    merge = 1'b0;
`endif
    exp_ready = (mq.size() < DEPTH) || merge;
    chk("rnd_st_ready", {31'b0, st_ready}, {31'b0, exp_ready});
    chk("rnd_full", {31'b0, full_out}, {31'b0, mq.size() == DEPTH});
    chk("rnd_empty", {31'b0, empty_out}, {31'b0, mq.size() == 0});
    if (ld_req) begin
      model_fwd(ld_addr, ld_size, eh, ec, ed);
      chk("rnd_ld_hit", {31'b0, ld_hit}, {31'b0, eh});
      chk("rnd_ld_conflict", {31'b0, ld_conflict}, {31'b0, ec});
      if (eh) chk("rnd_ld_data", ld_data, ed);
    end
    if (prev_stall) begin
      chk("rnd_dc_hold_valid", {31'b0, dc_valid}, 32'd1);
      chk("rnd_dc_hold_addr", dc_addr, prev_addr);
    end
    hs = dc_valid && dc_ready;
    if (hs) begin
      if (mq.size() == 0) begin
        chk("rnd_beat_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rnd_dc_addr", dc_addr, {mq[0].w, 2'b00});
        chk("rnd_dc_be", {28'b0, dc_be}, {28'b0, mq[0].m});
        chk("rnd_dc_data", dc_data & m_bytes(dc_be), mq[0].d);
      end
    end
    prev_stall = dc_valid && !dc_ready;
    prev_addr  = dc_addr;
    accept = st_valid && dtlb_hit && exp_ready;
    @(posedge clk);
    if (hs && mq.size() > 0) void'(mq.pop_front());
    if (accept) begin
      sm = m_mask(st_addr[1:0], st_size); lo = int'(st_addr[1:0]);
      if (merge) e = mq[mq.size()-1];
      else begin e.w = st_addr[31:2]; e.m = 4'b0; e.d = '0; end
      e.m = e.m | sm;
      for (int b = 0; b < 4; b++) if (sm[b]) e.d[8*b +: 8] = st_data[8*(b-lo) +: 8];
      if (merge) mq[mq.size()-1] = e;
      else mq.push_back(e);
    end
    #1;
  endtask

  initial begin
    // Test 1: reset state and single word store drain
    do_reset();
    chk("rst_dc_valid", {31'b0, dc_valid}, 32'd0);
    chk("rst_empty", {31'b0, empty_out}, 32'd1);
    chk("rst_full", {31'b0, full_out}, 32'd0);
    chk("rst_dc_addr", dc_addr, 32'h0);
    dc_ready = 1'b1;
    push(32'h100, 32'hAABBCCDD, 2'b10);
    #1 chk("t1_st_ready", {31'b0, st_ready}, 32'd1);
    tick();
    st_valid = 1'b0;
    chk("t1_dc_valid_early", {31'b0, dc_valid}, 32'd0);
    tick();
    chk("t1_dc_valid", {31'b0, dc_valid}, 32'd1);
    chk("t1_dc_addr", dc_addr, 32'h100);
    chk("t1_dc_be", {28'b0, dc_be}, 32'hF);
    chk("t1_dc_data", dc_data, 32'hAABBCCDD);
    tick();
    chk("t1_empty", {31'b0, empty_out}, 32'd1);
    chk("t1_dc_valid_low", {31'b0, dc_valid}, 32'd0);

    // Test 2: fill, reject 5th, FIFO-order drain
    dc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'h600 + 32'(i) * 4, 32'(i), 2'b10);
      tick();
    end
    push(32'h610, 32'h55, 2'b10);
    ld_req = 1'b1; ld_addr = 32'h610; ld_size = 2'b10;
    #1;
    chk("t2_full", {31'b0, full_out}, 32'd1);
    chk("t2_st_ready", {31'b0, st_ready}, 32'd0);
    tick();
    st_valid = 1'b0;
    #1 chk("t2_no_fwd_5th", {31'b0, ld_hit}, 32'd0);
    ld_req = 1'b0;
    chk("t2_still_full", {31'b0, full_out}, 32'd1);
    chk("t2_first_addr", dc_addr, 32'h600);
    dc_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t2_order_addr", dc_addr, 32'h600 + 32'(i) * 4);
      chk("t2_order_data", dc_data, 32'(i));
    end
    tick();
    chk("t2_empty", {31'b0, empty_out}, 32'd1);

    // Test 3: partial overlap vs exact byte hit
    dc_ready = 1'b0;
    push(32'h203, 32'h11, 2'b00);
    tick();
    st_valid = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h202; ld_size = 2'b01;
    #1;
    chk("t3_conflict", {31'b0, ld_conflict}, 32'd1);
    chk("t3_no_hit", {31'b0, ld_hit}, 32'd0);
    ld_addr = 32'h203; ld_size = 2'b00;
    #1;
    chk("t3_hit", {31'b0, ld_hit}, 32'd1);
    chk("t3_data", ld_data, 32'h11);
    ld_req = 1'b0;
    drain_all("t3_drain");

    // Test 4: word then byte to the same word
    push(32'h300, 32'h01020304, 2'b10);
    tick();
    push(32'h301, 32'hFF, 2'b00);
    tick();
    st_valid = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h300; ld_size = 2'b10;
    #1;
`ifdef SB_COALESCE_EN
    chk("t4_hit", {31'b0, ld_hit}, 32'd1);
    chk("t4_data", ld_data, 32'h0102FF04);
`else
    chk("t4_conflict", {31'b0, ld_conflict}, 32'd1);
    chk("t4_no_hit", {31'b0, ld_hit}, 32'd0);
`endif
    ld_req = 1'b0;
    tick();
    chk("t4_beat0_be", {28'b0, dc_be}, 32'hF);
`ifdef SB_COALESCE_EN
    chk("t4_beat0_data", dc_data, 32'h0102FF04);
    dc_ready = 1'b1;
    tick();
    chk("t4_one_entry", {31'b0, empty_out}, 32'd1);
`else
    chk("t4_beat0_data", dc_data, 32'h01020304);
    dc_ready = 1'b1;
    tick();
    chk("t4_beat1_be", {28'b0, dc_be}, 32'h2);
    chk("t4_beat1_data", dc_data & 32'h0000FF00, 32'h0000FF00);
`endif
    drain_all("t4_drain");

    // Test 5: misaligned half store
    push(32'h401, 32'h1234, 2'b01);
    tick();
    st_valid = 1'b0;
    chk("t5_misalign_pulse", {31'b0, st_misalign}, 32'd1);
    chk("t5_not_stored", {31'b0, empty_out}, 32'd1);
    tick();
    chk("t5_pulse_end", {31'b0, st_misalign}, 32'd0);
    push(32'h401, 32'h1234, 2'b01);
    dtlb_hit = 1'b0;
    tick();
    st_valid = 1'b0; dtlb_hit = 1'b1;
    chk("t5_tlb_miss_no_pulse", {31'b0, st_misalign}, 32'd0);
    chk("t5_tlb_miss_empty", {31'b0, empty_out}, 32'd1);

    // Test 6: reset during SEND
    dc_ready = 1'b0;
    push(32'h700, 32'h77, 2'b10);
    tick();
    push(32'h704, 32'h78, 2'b10);
    tick();
    st_valid = 1'b0;
    tick();
    chk("t6_sending", {31'b0, dc_valid}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t6_dc_valid", {31'b0, dc_valid}, 32'd0);
    chk("t6_empty", {31'b0, empty_out}, 32'd1);
    ld_req = 1'b1; ld_addr = 32'h700; ld_size = 2'b10;
    #1 chk("t6_no_hit_700", {31'b0, ld_hit}, 32'd0);
    ld_addr = 32'h704;
    #1 chk("t6_no_hit_704", {31'b0, ld_hit}, 32'd0);
    ld_req = 1'b0;

    // Randomized traffic against the queue model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      st_valid = ($urandom_range(0, 99) < 55);
      st_size  = 2'($urandom_range(0, 2));
      st_addr  = rand_addr(st_size);
      st_data  = $urandom;
      dtlb_hit = ($urandom_range(0, 99) < 90);
      ld_req   = ($urandom_range(0, 99) < 60);
      ld_size  = 2'($urandom_range(0, 2));
      ld_addr  = rand_addr(ld_size);
      dc_ready = ($urandom_range(0, 99) < 45);
      run_cycle();
    end
    st_valid = 1'b0; ld_req = 1'b0; dc_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (mq.size() == 0 && !dc_valid) break;
      run_cycle();
    end
    chk("rnd_final_empty", {31'b0, empty_out}, 32'd1);
    chk("rnd_final_model", 32'(mq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_buffer_coalesce.md
Name: store_buffer_coalesce

Overview:
- Parametrised successor store buffer between the LSU and the write port of the data cache.
- Holds retired stores as word-aligned entries, each with a per-byte enable mask, in a circular FIFO of configurable depth.
- Adds byte/half/word stores, youngest-first store-to-load forwarding with partial-overlap conflict detection, and a valid/ready drain handshake to the dcache.
- Optionally merges a new store into an existing entry for the same word.

Parameters:
- SB_DEPTH, 4, number of entries; power of two, ≥2.
- ADDR_W, 32, address width; entries store ADDR_W-2 word bits.
- CNT_W, $clog2(SB_DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- st_valid  in  1  store push request
- st_ready  out  1  push can be accepted this cycle (combinational)
- st_addr  in  ADDR_W  store byte address
- st_data  in  32  store data, right-aligned
- st_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- dtlb_hit  in  1  translation valid; push ignored when 0
- st_misalign  out  1  one-cycle pulse: push rejected as misaligned
- ld_req  in  1  forwarding lookup
- ld_addr  in  ADDR_W  load byte address
- ld_size  in  2  encoding as st_size
- ld_hit  out  1  all requested bytes supplied by the buffer (combinational)
- ld_conflict  out  1  partial overlap; LSU must stall the load (combinational)
- ld_data  out  32  forwarded bytes, right-aligned, zero-extended
- drain_force  in  1  fence: drain even while stores arrive
- dc_valid  out  1  registered drain request
- dc_ready  in  1  dcache accepts the drain beat
- dc_addr  out  ADDR_W  word-aligned address, low 2 bits 0
- dc_data  out  32  lane-positioned data
- dc_be  out  4  byte enables
- full_out  out  1  count == SB_DEPTH
- empty_out  out  1  count == 0

Behaviour:
Reset:
- While reset_n=0 at a clk edge: head=tail=count=0, all entries invalid, dc_valid=0, dc_addr/dc_data/dc_be=0, drain FSM to IDLE.
- A reset during SEND drops dc_valid at that edge regardless of dc_ready.

Store mask and lanes:
- byte mask = 1<<a[1:0]; half mask = 0011<<a[1:0]; word mask = 1111.
- Lane data = st_data shifted left by 8*a[1:0].
- Misaligned cases: half with a[0]=1, word with a[1:0]≠0, size 11. st_misalign pulses for one cycle; nothing is stored.

Push acceptance:
- Accepted when st_valid && dtlb_hit && aligned && st_ready.
- st_ready = !full_out || merge_target_exists.
- Allocate: write {word addr, mask, lane data} at head; set valid; head = (head+1) mod SB_DEPTH; count+1.

Drain FSM (IDLE, SEND):
- Drain condition = !empty && (full || !st_valid || drain_force).
- IDLE: if the drain condition holds, load dc_* from entry[tail], set dc_valid=1, go to SEND.
- SEND: dc_* are held stable until dc_ready. On handshake: invalidate entry[tail], tail+1 mod SB_DEPTH, count-1.
  - If the drain condition still holds with count>1, load the next entry back-to-back and stay in SEND.
  - Otherwise dc_valid=0 and go to IDLE.
- The entry being drained stays valid and visible to forwarding until its handshake.

Simultaneous events and boundaries:
- Allocate and pop in the same cycle leave count unchanged.
- st_ready uses the count at cycle start: a full buffer rejects an allocating push even if a pop completes that cycle.
- Pointers wrap modulo SB_DEPTH.

Forwarding:
- Scan valid entries youngest (head-1) to oldest (tail).
- The first entry whose word address matches and whose mask intersects the load mask decides:
  - its mask covers the whole load mask: ld_hit=1, ld_data = bytes shifted right by 8*a[1:0], zero-extended;
  - otherwise: ld_conflict=1.
- No intersecting entry: both 0.
- The lookup sees pre-edge state; a same-cycle push is not visible.
- ld_hit=ld_conflict=0 whenever ld_req=0.

Optional Feature:
- Macro: SB_COALESCE_EN.
- Defined: a push whose word address matches the youngest valid entry that is not currently in SEND merges into it. Masked bytes are overwritten, mask |= new mask, no allocation, and the push is allowed while full.
- Undefined: every accepted push allocates a new entry; merge_target_exists is constant 0.

Decomposition:
- Shared package: size encoding constants (SZ_BYTE/SZ_HALF/SZ_WORD), byte-mask generation function, lane-shift function, and the SB_DEPTH default alongside the existing definitions.
- One sub-module, sb_fwd_lookup: combinational youngest-first priority match producing ld_hit, ld_conflict and ld_data.

Test Plan:
1. Word store 0x100=0xAABBCCDD into an empty buffer, then idle, dc_ready=1:
   - dc_valid rises 1 cycle after push;
   - dc_addr=0x100, dc_be=1111;
   - empty_out=1 after handshake.
2. SB_DEPTH=4: fill with 4 stores while dc_ready=0; a 5th store to a new word:
   - full_out=1, st_ready=0, entry not stored.
   - Raise dc_ready: entries drain in FIFO order, one per cycle.
3. Byte store 0x203=0x11, then load half at 0x202:
   - ld_conflict=1, ld_hit=0.
   - Load byte at 0x203: ld_hit=1, ld_data=0x00000011.
4. Stores 0x300=0x01020304 (word) then 0x301=0xFF (byte); load word at 0x300:
   - SB_COALESCE_EN defined: one entry with data 0x0102FF04, ld_hit=1, ld_data=0x0102FF04.
   - SB_COALESCE_EN undefined: two entries; the youngest intersecting entry (the byte store) only partially covers the load, so ld_conflict=1, ld_hit=0.
5. Half store at 0x401:
   - st_misalign pulses for one cycle; count unchanged.
   - Same store with dtlb_hit=0: ignored, no pulse.
6. Assert reset_n=0 while dc_valid=1 and dc_ready=0:
   - next cycle dc_valid=0, empty_out=1, ld_hit=0 for all previously stored addresses.
